// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner.
// A prescaler sets the dwell time of each digit. The first GHOST cycles of each
// dwell are blanked so that a digit's segments are not shown while the
// selection changes. New display values are double-buffered and change only at
// a frame boundary. Leading zeros can optionally be blanked.
module seven_seg_scanner #(
  parameter int DIV   = 50000,
  parameter int GHOST = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        blank_lz,
  output logic [3:0]  digit_nibble,
  output logic [3:0]  digit_sel,
  output logic        frame_done
);

  localparam int CW = $clog2(DIV);

  typedef enum logic [1:0] {D0, D1, D2, D3} state_t;

  state_t        state_p0;
  state_t        state_nxt;
  logic [CW-1:0] cnt_p0;
  logic [15:0]   pending_p0;
  logic [15:0]   active_p0;
  logic          pend_p0;
  logic          blank_lz_p0;
  logic          frame_done_p0;
  logic          tick;
  logic          xfer;
  logic          ghost;
  logic          blanked;

  // Active-low one-hot enable for the digit scanned in a given state.
  function automatic logic [3:0] sel_for(input state_t s);
    logic [3:0] onehot;
    onehot = 4'b0001 << s;
    return ~onehot;
  endfunction

  assign tick = (cnt_p0 == CW'(DIV - 1));
  assign xfer = tick && (state_p0 == D3);

  // Prescaler: counts 0..DIV-1; the wrap cycle is the digit-advance tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
    end else if (tick) begin
      cnt_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_p0 + CW'(1);
    end
  end

  // Scan state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= D0;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  // Next-state: advance one digit per tick, wrapping D3 back to D0.
  always_comb begin
    state_nxt = state_p0;
    if (tick) begin
      case (state_p0)
        D0:      state_nxt = D1;
        D1:      state_nxt = D2;
        D2:      state_nxt = D3;
        default: state_nxt = D0;
      endcase
    end
  end

  // Double buffer: writes land in pending; active is loaded only at the frame
  // boundary. A write on the transfer tick itself stays pending for next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_p0 <= '0;
      active_p0  <= '0;
      pend_p0    <= 1'b0;
    end else begin
      if (xfer && pend_p0) begin
        active_p0 <= pending_p0;
      end
      if (wr_en) begin
        pending_p0 <= wr_data;
        pend_p0    <= 1'b1;
      end else if (xfer) begin
        pend_p0 <= 1'b0;
      end
    end
  end

  // Register blank_lz and the frame pulse so no input reaches an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_lz_p0   <= 1'b0;
      frame_done_p0 <= 1'b0;
    end else begin
      blank_lz_p0   <= blank_lz;
      frame_done_p0 <= xfer;
    end
  end

  // Output decode from registered state: nibble select, ghost window, leading-zero blanking.
  always_comb begin
    digit_nibble = 4'h0;
    blanked      = 1'b0;
    case (state_p0)
      D0: begin
        digit_nibble = active_p0[3:0];
        blanked      = 1'b0;
      end
      D1: begin
        digit_nibble = active_p0[7:4];
        blanked      = blank_lz_p0 && (active_p0[15:4] == 12'h000);
      end
      D2: begin
        digit_nibble = active_p0[11:8];
        blanked      = blank_lz_p0 && (active_p0[15:8] == 8'h00);
      end
      default: begin
        digit_nibble = active_p0[15:12];
        blanked      = blank_lz_p0 && (active_p0[15:12] == 4'h0);
      end
    endcase
    ghost     = (cnt_p0 < CW'(GHOST));
    digit_sel = 4'b1111;
    if (!ghost && !blanked) begin
      digit_sel = sel_for(state_p0);
    end
  end

  assign frame_done = frame_done_p0;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with DIV=8, GHOST=2.
// The stimulus process queues the expected output triple for every scan cycle;
// a monitor on the falling edge pops and compares entries as their cycle comes up.
module tb_seven_seg_scanner;

  localparam int DIV   = 8;
  localparam int GHOST = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  digit_nibble;
  logic [3:0]  digit_sel;
  logic        frame_done;

  typedef struct {
    int         cyc;   // -1: check while reset is asserted
    logic [8:0] v;     // {digit_nibble, digit_sel, frame_done}
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   applied = 0;
  int   errs    = 0;
  int   mcyc    = 0;
  int   scyc    = 0;

  seven_seg_scanner #(.DIV(DIV), .GHOST(GHOST)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .blank_lz     (blank_lz),
    .digit_nibble (digit_nibble),
    .digit_sel    (digit_sel),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  // Queue the expected outputs for one frame f showing value v, up to cycle last.
  task automatic push_frame(input int f, input logic [15:0] v, input bit blz, input int last);
    exp_t       x;
    logic [3:0] s;
    logic [3:0] nib;
    logic [15:0] upper;
    bit         blk;
    for (int k = 0; k < 4; k++) begin
      upper = v >> (4 * k);
      nib   = upper[3:0];
      blk   = blz && (k > 0) && (upper == 16'h0000);
      for (int c = 0; c < DIV; c++) begin
        x.cyc = f * FRAME + k * DIV + c;
        if (x.cyc <= last) begin
          s = 4'b0001 << k;
          s = ~s;
          if (c < GHOST || blk) s = 4'b1111;
          x.v = {nib, s, (f > 0 && k == 0 && c == 0) ? 1'b1 : 1'b0};
          q.push_back(x);
        end
      end
    end
  endtask

  task automatic push_reset_check();
    exp_t x;
    x.cyc = -1;
    x.v   = {4'h0, 4'b1111, 1'b0};
    q.push_back(x);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
    scyc++;
  endtask

  task automatic wait_until(input int n);
    while (scyc < n) next_cycle();
  endtask

  task automatic write(input int n, input logic [15:0] d);
    wait_until(n);
    wr_en   = 1'b1;
    wr_data = d;
    next_cycle();
    wr_en   = 1'b0;
  endtask

  // Monitor: compare the DUT against the queue entry due at this cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (q.size() > 0 && q[0].cyc == -1) begin
        e = q.pop_front();
        applied++;
        if ({digit_nibble, digit_sel, frame_done} !== e.v) begin
          errs++;
          $display("FAIL reset_outputs: got nib=%h sel=%b fd=%b, want nib=%h sel=%b fd=%b",
                   digit_nibble, digit_sel, frame_done, e.v[8:5], e.v[4:1], e.v[0]);
        end
      end
      mcyc = 0;
    end else begin
      while (q.size() > 0 && q[0].cyc >= 0 && q[0].cyc < mcyc) begin
        e = q.pop_front();
        applied++;
        errs++;
        $display("FAIL missed_vector: cycle %0d never checked, now at cycle %0d", e.cyc, mcyc);
      end
      if (q.size() > 0 && q[0].cyc == mcyc) begin
        e = q.pop_front();
        applied++;
        if ({digit_nibble, digit_sel, frame_done} !== e.v) begin
          errs++;
          $display("FAIL scan_cycle_%0d: got nib=%h sel=%b fd=%b, want nib=%h sel=%b fd=%b",
                   mcyc, digit_nibble, digit_sel, frame_done, e.v[8:5], e.v[4:1], e.v[0]);
        end
      end
      mcyc++;
    end
  end

  // Stimulus: directed write/blanking scenarios across eight frames, then a mid-frame reset.
  initial begin
    push_reset_check();
    push_frame(0, 16'h0000, 1'b0, 1000);  // idle after reset
    push_frame(1, 16'h12AF, 1'b0, 1000);  // write at cycle 10 shown from frame 1
    push_frame(2, 16'h2222, 1'b0, 1000);  // back-to-back writes: last wins
    push_frame(3, 16'h0030, 1'b1, 1000);  // leading-zero blanking of D2/D3
    push_frame(4, 16'h0030, 1'b0, 1000);  // blanking off: all shown
    push_frame(5, 16'h1234, 1'b0, 1000);  // pending value at transfer tick
    push_frame(6, 16'hBEEF, 1'b0, 1000);  // write on the transfer tick
    push_frame(7, 16'hBEEF, 1'b0, 7 * FRAME + 2 * DIV + 1);

    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    scyc = 0;

    write(10, 16'h12AF);
    write(40, 16'h1111);
    write(41, 16'h2222);
    wait_until(70);
    blank_lz = 1'b1;
    write(70, 16'h0030);
    wait_until(4 * FRAME - 1);
    blank_lz = 1'b0;
    write(140, 16'h1234);
    write(5 * FRAME - 1, 16'hBEEF);
    write(230, 16'h5678);

    // Reset for one cycle during D2 with 5678 still pending.
    wait_until(7 * FRAME + 2 * DIV + 2);
    push_reset_check();
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    scyc = 0;
    push_frame(0, 16'h0000, 1'b0, 1000);
    push_frame(1, 16'h0000, 1'b0, 1000);

    for (int i = 0; i < 4 * FRAME && q.size() > 0; i++) next_cycle();
    if (q.size() > 0) begin
      applied++;
      errs++;
      $display("FAIL drain_timeout: %0d vectors left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter DIV, default 50000: refresh prescaler, clock cycles per digit dwell; legal range 4..2^20.
REQ-002 Parameter GHOST, default 500: anti-ghost blanking cycles at start of each dwell; legal range 1..DIV-2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  write strobe for display value, sampled each clk.
REQ-006 wr_data  input  16  four hex nibbles, [3:0] = digit 0 (rightmost).
REQ-007 blank_lz  input  1  leading-zero blanking enable, sampled each clk.
REQ-008 digit_nibble  output  4  nibble of the currently scanned digit; drives the seven-segment decoder address.
REQ-009 digit_sel  output  4  active-low digit enables, one-hot-low or all-high.
REQ-010 frame_done  output  1  single-cycle pulse at end of each 4-digit scan frame.

Function
REQ-011 Outputs SHALL be functions of internal registers only; no combinational path from any input to any output.
REQ-012 Prescaler counts 0..DIV-1, increments every cycle, wraps to 0; the wrap cycle is the "tick".
REQ-013 Scan FSM states D0, D1, D2, D3; on tick D0->D1->D2->D3->D0; no other transitions.
REQ-014 digit_nibble = active[4k+3:4k] in state Dk.
REQ-015 digit_sel = 4'b1111 while prescaler < GHOST; otherwise bit k low, others high, in state Dk, unless Dk is blanked.
REQ-016 Dk (k=1..3) blanked when blank_lz=1 and active nibbles k..3 all zero; D0 never blanked; blanked digit -> digit_sel = 4'b1111 for the whole dwell.
REQ-017 Two registers: pending (16b) and active (16b), plus flag pend.
REQ-018 wr_en=1 -> pending <= wr_data, pend <= 1 next edge; back-to-back writes: last write wins.
REQ-019 Transfer on tick in D3 (D3->D0): if pend=1, active <= pending, pend <= 0; active never changes mid-frame.
REQ-020 wr_en=1 on the transfer tick: active <= old pending; pending <= wr_data; pend stays 1 (new value shown next frame).
REQ-021 wr_en while pend=0 at transfer tick: same as REQ-020 case when pend was 0 -> active unchanged, pend <= 1.
REQ-022 frame_done registered: high for exactly the one cycle after the D3->D0 tick, i.e. first cycle of D0.
REQ-023 Frame length exactly 4*DIV cycles; frame_done period exactly 4*DIV cycles.

Reset
REQ-024 rst=1 asynchronously forces: prescaler=0, state=D0, pending=0, active=0, pend=0, frame_done=0.
REQ-025 Reset-state outputs: digit_nibble=4'h0, digit_sel=4'b1111 (ghost window), frame_done=0.
REQ-026 Reset mid-frame or mid-write discards the pending write; after release scanning restarts at D0, prescaler 0, first tick after DIV cycles.

Verification (DIV=8, GHOST=2)
REQ-027 Release reset, no writes -> digit_sel 1111 for cycles 0-1, 1110 cycles 2-7, then 1111,1111,1101x6, ...; digit_nibble 0 throughout; frame_done first at cycle 32.
REQ-028 Write 16'h12AF mid-frame -> active stays 0 until D3->D0 tick; next frame nibbles F,A,2,1 on D0..D3.
REQ-029 blank_lz=1, active=16'h0030 -> D0 nibble 0 shown, D1 nibble 3 shown, D2/D3 digit_sel 1111 whole dwell; blank_lz=0 -> all four shown.
REQ-030 Writes 16'h1111 then 16'h2222 on consecutive cycles before tick -> next frame shows 2222 only.
REQ-031 wr_en with 16'hBEEF exactly on transfer tick while pend holds 16'h1234 -> next frame 1234, following frame BEEF.
REQ-032 Assert rst for 1 cycle during D2 with pending write outstanding -> all registers at reset values immediately; pending value never displayed.
